// File: rtl/iir_capture_buffer.sv
// Capture buffer for the IIR output stream: records L samples after arm, then
// streams them back oldest-first. Optional min/max tracking: IIR_CAPTURE_MINMAX_EN.
module iir_capture_buffer #(
    parameter int N_BITS    = 32,
    parameter int DEPTH     = 2048,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm_i,
    input  logic [ADDR_BITS:0]   n_samples_i,
    input  logic [N_BITS-1:0]    sample_i,
    input  logic                 sample_valid_i,
    input  logic                 dump_i,
    input  logic                 rd_ready_i,
    output logic [N_BITS-1:0]    rd_data_o,
    output logic                 rd_valid_o,
    output logic                 rd_last_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ADDR_BITS:0]   count_o,
    output logic [N_BITS-1:0]    min_o,
    output logic [N_BITS-1:0]    max_o
);

    localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE,
        S_READOUT
    } state_t;

    typedef struct packed {
        logic                 en;
        logic [ADDR_BITS-1:0] addr;
        logic [N_BITS-1:0]    data;
    } wr_req_t;

    state_t               state;
    logic [ADDR_BITS:0]   len_q;
    logic [ADDR_BITS:0]   len_sel;
    logic [ADDR_BITS:0]   count_nxt;
    logic [ADDR_BITS:0]   rd_addr;
    logic                 rd_issue;
    logic                 rd_xfer;
    wr_req_t              wr;

    logic [N_BITS-1:0] mem [DEPTH];

    // Zero or oversize lengths fall back to a full-depth capture.
    always_comb begin
        len_sel = n_samples_i;
        if (n_samples_i == '0 || n_samples_i > DEPTH_L)
            len_sel = DEPTH_L;
    end

    always_comb begin
        wr.en   = (state == S_CAPTURE) && sample_valid_i;
        wr.addr = count_o[ADDR_BITS-1:0];
        wr.data = sample_i;
    end

    assign count_nxt = count_o + 1'b1;

    always_ff @(posedge clk) begin
        if (wr.en)
            mem[wr.addr] <= wr.data;
    end

    // The RAM output register is the readout register; its read enable is the
    // stall, so a held beat keeps data stable and ready-high gives one per cycle.
    assign rd_xfer  = rd_valid_o && rd_ready_i;
    assign rd_issue = (state == S_READOUT) && (!rd_valid_o || rd_ready_i)
                      && (rd_addr != len_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            count_o    <= '0;
            len_q      <= '0;
            rd_addr    <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm_i) begin
                        len_q   <= len_sel;
                        count_o <= '0;
                        busy_o  <= 1'b1;
                        state   <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (sample_valid_i) begin
                        count_o <= count_nxt;
                        if (count_nxt == len_q) begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (dump_i) begin
                        rd_addr <= '0;
                        done_o  <= 1'b0;
                        busy_o  <= 1'b1;
                        state   <= S_READOUT;
                    end
                end
                S_READOUT: begin
                    if (rd_issue) begin
                        rd_data_o  <= mem[rd_addr[ADDR_BITS-1:0]];
                        rd_valid_o <= 1'b1;
                        rd_last_o  <= ((rd_addr + 1'b1) == len_q);
                        rd_addr    <= rd_addr + 1'b1;
                    end else if (rd_xfer) begin
                        rd_valid_o <= 1'b0;
                        rd_last_o  <= 1'b0;
                    end
                    if (rd_xfer && rd_last_o) begin
                        rd_valid_o <= 1'b0;
                        rd_last_o  <= 1'b0;
                        busy_o     <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IIR_CAPTURE_MINMAX_EN
    localparam logic [N_BITS-1:0] POS_MAX = {1'b0, {(N_BITS-1){1'b1}}};
    localparam logic [N_BITS-1:0] NEG_MIN = {1'b1, {(N_BITS-1){1'b0}}};

    logic arm_acc;
    assign arm_acc = (state == S_IDLE) && arm_i;

    // Extremes start inverted on arm so the first written sample sets both.
    always_ff @(posedge clk) begin
        if (reset) begin
            min_o <= '0;
            max_o <= '0;
        end else if (arm_acc) begin
            min_o <= POS_MAX;
            max_o <= NEG_MIN;
        end else if (wr.en) begin
            if ($signed(wr.data) < $signed(min_o))
                min_o <= wr.data;
            if ($signed(wr.data) > $signed(max_o))
                max_o <= wr.data;
        end
    end
`else
    assign min_o = '0;
    assign max_o = '0;
`endif

endmodule

// File: tb/tb_iir_capture_buffer.sv
// Directed bench for iir_capture_buffer: capture, readout, backpressure,
// full-depth capture with gaps, reset abort and ignored commands.
module tb_iir_capture_buffer;

    localparam int N_BITS    = 32;
    localparam int DEPTH     = 2048;
    localparam int ADDR_BITS = 11;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 arm_i;
    logic [ADDR_BITS:0]   n_samples_i;
    logic [N_BITS-1:0]    sample_i;
    logic                 sample_valid_i;
    logic                 dump_i;
    logic                 rd_ready_i;
    logic [N_BITS-1:0]    rd_data_o;
    logic                 rd_valid_o;
    logic                 rd_last_o;
    logic                 busy_o;
    logic                 done_o;
    logic [ADDR_BITS:0]   count_o;
    logic [N_BITS-1:0]    min_o;
    logic [N_BITS-1:0]    max_o;

    int n_chk  = 0;
    int n_pass = 0;

    iir_capture_buffer #(.N_BITS(N_BITS), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .reset(reset), .arm_i(arm_i), .n_samples_i(n_samples_i),
        .sample_i(sample_i), .sample_valid_i(sample_valid_i), .dump_i(dump_i),
        .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .rd_last_o(rd_last_o), .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
        .min_o(min_o), .max_o(max_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [N_BITS-1:0] s1 [4] = '{32'h0001_0000, 32'h0000_8000, 32'hFFFF_0000, 32'h0000_0001};
    logic [N_BITS-1:0] s2 [4] = '{32'h1111_1111, 32'h8000_0002, 32'h7FFF_FFF3, 32'h4444_4444};
    logic              bp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int nx, errs, idx;
        logic held;
        logic [N_BITS-1:0] hold_v;

        reset = 1'b1; arm_i = 1'b0; n_samples_i = '0; sample_i = '0;
        sample_valid_i = 1'b0; dump_i = 1'b0; rd_ready_i = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_last", rd_last_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_data", rd_data_o, 0);
        chk("rst_min", min_o, 0);
        chk("rst_max", max_o, 0);
        reset = 1'b0;

        // Capture of 4; a stray sample on the arm cycle must be ignored.
        arm_i = 1'b1; n_samples_i = 4; sample_valid_i = 1'b1; sample_i = 32'h0000_DEAD;
        tick();
        arm_i = 1'b0; sample_valid_i = 1'b0;
        chk("arm_busy", busy_o, 1);
        chk("arm_count", count_o, 0);
        for (int i = 0; i < 4; i++) begin
            sample_i = s1[i]; sample_valid_i = 1'b1;
            tick();
            if (i == 2) chk("done_early", done_o, 0);
        end
        sample_valid_i = 1'b0;
        chk("cap_done", done_o, 1);
        chk("cap_busy", busy_o, 0);
        chk("cap_count", count_o, 4);
`ifdef IIR_CAPTURE_MINMAX_EN
        chk("cap_min", min_o, 32'hFFFF_0000);
        chk("cap_max", max_o, 32'h0001_0000);
`else
        chk("cap_min", min_o, 0);
        chk("cap_max", max_o, 0);
`endif

        // Readout with ready held high.
        rd_ready_i = 1'b1; dump_i = 1'b1;
        tick();
        dump_i = 1'b0;
        chk("dump_t1_valid", rd_valid_o, 0);
        chk("dump_t1_busy", busy_o, 1);
        chk("dump_t1_done", done_o, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("rd_valid", rd_valid_o, 1);
            chk("rd_data", rd_data_o, s1[i]);
            chk("rd_last", rd_last_o, (i == 3) ? 1 : 0);
            tick();
        end
        chk("rd_end_valid", rd_valid_o, 0);
        chk("rd_end_last", rd_last_o, 0);
        chk("rd_end_busy", busy_o, 0);
        chk("rd_end_count", count_o, 4);

        // Backpressure readout of a fresh capture.
        arm_i = 1'b1; n_samples_i = 4;
        tick();
        arm_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_i = s2[i]; sample_valid_i = 1'b1;
            tick();
        end
        sample_valid_i = 1'b0;
        chk("bp_cap_done", done_o, 1);
`ifdef IIR_CAPTURE_MINMAX_EN
        chk("bp_min", min_o, 32'h8000_0002);
        chk("bp_max", max_o, 32'h7FFF_FFF3);
`endif
        rd_ready_i = 1'b0; dump_i = 1'b1;
        tick();
        dump_i = 1'b0;
        nx = 0;
        for (int c = 0; c < 40 && nx < 4; c++) begin
            rd_ready_i = bp[c % 4];
            if (rd_valid_o && rd_ready_i) begin
                chk("bp_data", rd_data_o, s2[nx]);
                chk("bp_last", rd_last_o, (nx == 3) ? 1 : 0);
                nx++;
            end
            held = rd_valid_o && !rd_ready_i;
            hold_v = rd_data_o;
            tick();
            if (held) begin
                chk("bp_hold_valid", rd_valid_o, 1);
                chk("bp_hold_data", rd_data_o, hold_v);
            end
        end
        chk("bp_xfers", nx, 4);
        chk("bp_end_valid", rd_valid_o, 0);
        chk("bp_end_busy", busy_o, 0);

        // Full-depth capture (length 0), every 3rd cycle idle.
        arm_i = 1'b1; n_samples_i = 0;
        tick();
        arm_i = 1'b0;
        idx = 0;
        for (int c = 0; c < 5000 && idx < DEPTH; c++) begin
            sample_valid_i = (c % 3 != 2);
            sample_i = idx;
            tick();
            if (sample_valid_i) idx++;
        end
        sample_valid_i = 1'b0;
        chk("full_count", count_o, 2048);
        chk("full_done", done_o, 1);
        sample_valid_i = 1'b1; sample_i = 32'h1234;
        repeat (3) tick();
        sample_valid_i = 1'b0;
        chk("full_extra_count", count_o, 2048);
        chk("full_extra_done", done_o, 1);
`ifdef IIR_CAPTURE_MINMAX_EN
        chk("full_min", min_o, 0);
        chk("full_max", max_o, 32'h0000_07FF);
`endif
        rd_ready_i = 1'b1; dump_i = 1'b1;
        tick();
        dump_i = 1'b0;
        tick();
        errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!rd_valid_o || rd_data_o !== i || rd_last_o !== (i == DEPTH-1)) errs++;
            if (i == DEPTH-1) begin
                chk("full_last_data", rd_data_o, 32'h0000_07FF);
                chk("full_last_flag", rd_last_o, 1);
            end
            tick();
        end
        chk("full_seq_errs", errs, 0);
        chk("full_end_busy", busy_o, 0);

        // Single-sample capture.
        arm_i = 1'b1; n_samples_i = 1;
        tick();
        arm_i = 1'b0;
        sample_i = 32'hDEAD_BEEF; sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        chk("one_done", done_o, 1);
        chk("one_count", count_o, 1);
        dump_i = 1'b1;
        tick();
        dump_i = 1'b0;
        tick();
        chk("one_valid", rd_valid_o, 1);
        chk("one_data", rd_data_o, 32'hDEAD_BEEF);
        chk("one_last", rd_last_o, 1);
        tick();
        chk("one_end_valid", rd_valid_o, 0);
        chk("one_end_busy", busy_o, 0);

        // Reset mid-capture; arm during CAPTURE ignored.
        arm_i = 1'b1; n_samples_i = 0;
        tick();
        arm_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            sample_i = i; sample_valid_i = 1'b1;
            if (i == 50) begin arm_i = 1'b1; n_samples_i = 5; end
            tick();
            arm_i = 1'b0;
        end
        sample_valid_i = 1'b0;
        chk("abort_pre_count", count_o, 100);
        chk("abort_pre_busy", busy_o, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_count", count_o, 0);
        chk("abort_done", done_o, 0);
        dump_i = 1'b1;
        tick();
        dump_i = 1'b0;
        tick();
        chk("idle_dump_valid", rd_valid_o, 0);
        chk("idle_dump_busy", busy_o, 0);
        chk("idle_dump_done", done_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/iir_capture_buffer.md
# iir_capture_buffer

Hardware capture and readout buffer for the IIR output stream. It records a programmed number of consecutive `y_o` samples into on-chip RAM after an arm command, then streams them back oldest-first over a valid/ready interface. It sits on the filter output, in the opposite direction to the sample source feeding `x_i`, so filter responses can be captured in silicon instead of by the bench file writer.

## Interface

Parameters:
- `N_BITS`, 32: sample width, Q16.16 two's complement.
- `DEPTH`, 2048: capture RAM depth; power of two.
- `ADDR_BITS`, 11: log2(`DEPTH`).

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `arm_i` input 1: start a capture; one-cycle pulse, honoured only in IDLE.
- `n_samples_i` input `ADDR_BITS+1`: capture length; latched on an accepted `arm_i`.
- `sample_i` input `N_BITS`: filter output (`y_o`).
- `sample_valid_i` input 1: `sample_i` is valid this cycle.
- `dump_i` input 1: start readout; one-cycle pulse, honoured only in DONE.
- `rd_ready_i` input 1: consumer accepts `rd_data_o`.
- `rd_data_o` output `N_BITS`: readout sample.
- `rd_valid_o` output 1: `rd_data_o` is valid.
- `rd_last_o` output 1: current `rd_data_o` is the final captured sample.
- `busy_o` output 1: state is CAPTURE or READOUT.
- `done_o` output 1: state is DONE.
- `count_o` output `ADDR_BITS+1`: number of samples written in the current or last capture.
- `min_o`, `max_o` output `N_BITS`: signed extremes of the capture (see Configuration).

## Operation

- States: IDLE, CAPTURE, DONE, READOUT.
- IDLE: `arm_i` latches length L and clears `count_o`, write pointer and min/max, then moves to CAPTURE.
  - `n_samples_i` = 0 or > `DEPTH` means L = `DEPTH`.
- CAPTURE: each cycle with `sample_valid_i` high writes `sample_i` to RAM[`count_o`] and increments `count_o`.
  - The write that makes `count_o` = L moves the FSM to DONE.
  - Gaps in `sample_valid_i` are allowed; no timeout.
- DONE: waits for `dump_i`, then moves to READOUT with the read pointer at 0.
- READOUT: presents RAM[0..L-1] in order.
  - A transfer occurs when `rd_valid_o` and `rd_ready_i` are both high.
  - The transfer with `rd_last_o` high returns the FSM to IDLE.
- Ignored inputs:
  - `arm_i` outside IDLE.
  - `dump_i` outside DONE.
  - `sample_valid_i` outside CAPTURE, including the arm cycle itself.
- `count_o` holds its value through DONE, READOUT and back into IDLE until the next arm.
- No wrap-around: capture stops at L and never overwrites.
- Reset values: state IDLE; `rd_valid_o`, `rd_last_o`, `busy_o`, `done_o` = 0; `count_o` = 0; `rd_data_o` = 0; `min_o`, `max_o` = 0.
  - RAM contents are not cleared.
- Reset mid-capture or mid-readout aborts the operation and returns to IDLE next cycle.

## Timing

- `arm_i` at cycle t: `busy_o` high at t+1; the first sample accepted is at t+1 or later.
- Last write at cycle t: `done_o` high and `busy_o` low at t+1.
- `dump_i` at cycle t: `rd_valid_o` high with RAM[0] at t+2 (address register plus synchronous RAM read).
- With `rd_ready_i` held high, throughput is one sample per cycle with no bubbles. The implementation needs a prefetch/skid stage for this.
- While `rd_valid_o` is high and `rd_ready_i` is low, `rd_data_o` and `rd_last_o` hold stable.
- After the last transfer at cycle t: `rd_valid_o`, `rd_last_o` and `busy_o` are low at t+1; state is IDLE.
- `rd_last_o` is asserted only together with `rd_valid_o`.

## Configuration

- Macro: `IIR_CAPTURE_MINMAX_EN`.
- Defined:
  - `min_o` and `max_o` track the signed minimum and maximum of the samples written in the current capture.
  - Both are updated the cycle after each write.
  - On arm, `min_o` resets to 0x7FFFFFFF and `max_o` to 0x80000000; values are held after capture.
- Undefined:
  - Tracking logic is absent and `min_o`/`max_o` are constant 0.
  - All other behaviour is identical.

## Test plan

- Reset → all outputs 0.
  - Then arm with `n_samples_i` = 4, drive 0x00010000, 0x00008000, 0xFFFF0000, 0x00000001 with `sample_valid_i` high.
  - Required: `done_o` high one cycle after the 4th sample, `count_o` = 4.
- From that DONE state, `dump_i` with `rd_ready_i` high.
  - Required: `rd_valid_o` rises 2 cycles later and the 4 values come out in order on consecutive cycles.
  - Required: `rd_last_o` only on 0x00000001, then IDLE.
- Readout backpressure: toggle `rd_ready_i` 1,0,0,1,…
  - Required: `rd_data_o` stable during low-ready cycles, no duplicates or drops, exactly 4 transfers.
- `n_samples_i` = 0, then 2048 samples of value = index with gaps every 3rd cycle.
  - Required: `count_o` = 2048, readout index 2047 = 0x000007FF with `rd_last_o`.
  - Extra `sample_valid_i` pulses after DONE do not change `count_o`.
- `reset` pulsed after 100 samples of a 2048-sample capture.
  - Required: IDLE next cycle, `busy_o` 0, `count_o` 0.
  - `arm_i` during CAPTURE and `dump_i` in IDLE have no effect.
- With `IIR_CAPTURE_MINMAX_EN` defined, capture from the first scenario.
  - Required: `min_o` = 0xFFFF0000, `max_o` = 0x00010000.
  - Without the macro, both read 0.
